// File: rtl/vending_fsm.sv
// Single-product (price 15) coin controller taking 5/10-unit coins; pr/change are
// registered pulses one cycle after the completing edge; no backpressure, one coin per clock.
module vending_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coin,
    output logic       pr,
    output logic       change
);

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S5  = 2'd1,
        S10 = 2'd2
    } state_t;

    localparam logic [1:0] COIN_5  = 2'd1;
    localparam logic [1:0] COIN_10 = 2'd2;

    state_t state_q, state_d;
    logic   pr_q, pr_d;
    logic   change_q, change_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S0;
            pr_q     <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pr_q     <= pr_d;
            change_q <= change_d;
        end
    end

    // Idle (0) and invalid (3) codes fall through the defaults: hold credit, no pulses.
    always_comb begin
        state_d  = state_q;
        pr_d     = 1'b0;
        change_d = 1'b0;
        unique case (state_q)
            S0: begin
                if (coin == COIN_5)       state_d = S5;
                else if (coin == COIN_10) state_d = S10;
            end
            S5: begin
                if (coin == COIN_5) begin
                    state_d = S10;
                end else if (coin == COIN_10) begin
                    state_d = S0;
                    pr_d    = 1'b1;
                end
            end
            S10: begin
                if (coin == COIN_5) begin
                    state_d = S0;
                    pr_d    = 1'b1;
                end else if (coin == COIN_10) begin
                    state_d  = S0;
                    pr_d     = 1'b1;
                    change_d = 1'b1;
                end
            end
            default: state_d = S0;
        endcase
    end

    assign pr     = pr_q;
    assign change = change_q;

endmodule

// File: tb/tb_vending_fsm.sv
// Scoreboard bench for vending_fsm: a credit model pushes expected {pr,change} per driven
// coin, and each entry is popped and compared one step after the sampling edge.
module tb_vending_fsm;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [1:0] coin = 2'd0;
    logic       pr;
    logic       change;

    int total = 0;
    int bad   = 0;
    int credit = 0;
    logic [1:0] exp_q[$];

    vending_fsm dut (
        .clk    (clk),
        .rst    (rst),
        .coin   (coin),
        .pr     (pr),
        .change (change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {pr,change}=%b expected %b", tag, got, exp);
        end
    endtask

    // Reference model: credit accumulates; reaching 15 or 20 vends and clears.
    task automatic model_push(input logic [1:0] c);
        int   add;
        int   sum;
        logic p;
        logic ch;
        p  = 1'b0;
        ch = 1'b0;
        add = (c == 2'd1) ? 5 : (c == 2'd2) ? 10 : 0;
        if (!rst) begin
            credit = 0;
        end else if (add > 0) begin
            sum = credit + add;
            if (sum >= 15) begin
                p      = 1'b1;
                ch     = (sum == 20);
                credit = 0;
            end else begin
                credit = sum;
            end
        end
        exp_q.push_back({p, ch});
    endtask

    task automatic step(input logic [1:0] c, input string tag);
        logic [1:0] exp;
        coin = c;
        model_push(c);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, {pr, change}, exp);
        end
    endtask

    initial begin
        // Reset held with a 10-unit coin present: nothing may accumulate.
        #1;
        chk("rst_init", {pr, change}, 2'b00);
        for (int i = 0; i < 3; i++) step(2'd2, "rst_hold");
        rst = 1'b1;
        step(2'd0, "rst_rel_idle");
        step(2'd0, "rst_rel_idle2");

        // 10 then 5: exact sale, single-cycle pulse.
        step(2'd2, "t10_5_a");
        step(2'd1, "t10_5_sale");
        step(2'd0, "t10_5_after");

        // 10 then 10: sale with change.
        step(2'd2, "t10_10_a");
        step(2'd2, "t10_10_sale");
        step(2'd0, "t10_10_after");

        // 5,5,5 held: each edge is a separate insertion.
        step(2'd1, "t555_1");
        step(2'd1, "t555_2");
        step(2'd1, "t555_sale");
        step(2'd0, "t555_after");

        // Invalid and idle codes interleaved are ignored.
        step(2'd1, "inv_5");
        step(2'd3, "inv_3");
        step(2'd3, "inv_3b");
        step(2'd0, "inv_0");
        step(2'd2, "inv_sale");
        step(2'd0, "inv_after");

        // Back-to-back: 20 completes, next 10 from S0 only stores credit.
        step(2'd2, "b2b_a");
        step(2'd2, "b2b_sale");
        step(2'd2, "b2b_next");
        step(2'd1, "b2b_sale2");
        step(2'd0, "b2b_after");

        // Async reset while pr is high: outputs drop without a clock edge.
        step(2'd2, "arst_pr_a");
        step(2'd1, "arst_pr_sale");
        #2;
        rst = 1'b0;
        #1;
        chk("arst_async_clear", {pr, change}, 2'b00);
        credit = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset mid-credit discards the 10 units.
        step(2'd2, "arst_mid_10");
        #2;
        rst = 1'b0;
        credit = 0;
        #1;
        chk("arst_mid_clear", {pr, change}, 2'b00);
        step(2'd1, "arst_mid_hold");
        rst = 1'b1;
        step(2'd1, "arst_post_5");
        step(2'd0, "arst_post_idle");
        step(2'd2, "arst_post_sale");
        step(2'd0, "arst_post_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_fsm.md
Name: vending_fsm

Overview:
- Coin-operated vending controller with a single product priced at 15 units.
- Accepts 5- and 10-unit coins, one coin per clock.
- Pulses pr (product dispense) for one cycle when the accumulated credit reaches the price, and pulses change when 5 units must be returned.
- Sits between the coin-acceptor interface and the dispense/return actuators.

Parameters:
- None. Price 15, coin values 5/10 and change value 5 are fixed.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; released synchronously by the driver)
- coin  input  2  coin code sampled every rising edge: 2'd0 none, 2'd1 = 5 units, 2'd2 = 10 units, 2'd3 invalid
- pr  output  1  product dispense pulse, registered
- change  output  1  5-unit change-return pulse, registered

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low, on port rst.
- States, encoded as credit held: S0 (0), S5 (5), S10 (10).
- Reset (rst=0, asynchronous): state=S0, pr=0, change=0. Held while rst=0 regardless of clk/coin.
- Coin sampling: coin is sampled on every rising edge while rst=1. A coin held at the same value across N edges counts as N insertions; there is no edge detection.
- coin=0 or coin=3: state unchanged, pr=0, change=0 next cycle. Invalid code 3 is ignored and no credit is given.
- Transitions (next state / pr / change, all registered on the same edge):
  - S0 + 5 -> S5 / 0 / 0
  - S0 + 10 -> S10 / 0 / 0
  - S5 + 5 -> S10 / 0 / 0
  - S5 + 10 -> S0 / 1 / 0 (exact 15)
  - S10 + 5 -> S0 / 1 / 0 (exact 15)
  - S10 + 10 -> S0 / 1 / 1 (20, return 5)
- Output timing:
  - pr and change are registered (Moore-style flops), not combinational from coin.
  - Each is high for exactly one cycle, the cycle following the completing edge.
  - Both deassert on the next edge unless that edge also completes a purchase.
- Back-to-back purchases: after returning to S0 the machine immediately accepts the next coin on the next edge. pr may stay high on consecutive cycles only if consecutive edges each complete a sale; this is unreachable from S0 in one coin.
- change never asserts without pr in the same cycle.
- Credit never exceeds 10 while stored; there is no overflow or wrap.
- Reset mid-transaction: credit discarded (no refund pulse), outputs forced to 0 asynchronously.
- After rst deasserts, the first rising edge with rst=1 processes coin normally.

Test Plan:
- Reset: drive rst=0 with coin=2 for 3 cycles -> pr=0, change=0, state S0 throughout; release, coin=0 -> outputs stay 0.
- 10 then 5: coin=2 one edge, coin=1 one edge, then coin=0 -> pr=1, change=0 for exactly one cycle after the second edge, then both 0.
- 10 then 10: coin=2 for two edges, then coin=0 -> pr=1, change=1 for one cycle, state S0.
- 5,5,5: coin=1 for three consecutive edges -> pr=0 after edges 1-2; pr=1, change=0 after edge 3.
- Invalid/idle coins interleaved: 5, 3, 0, 10 -> 3 and 0 ignored; pr=1, change=0 only after the 10-unit edge.
- Async reset mid-credit: coin 10, then assert rst=0 between edges -> pr/change stay 0, credit cleared; a subsequent single 5 coin gives no pr.
